sig_reg_writer: RTL and testbench



---
 rtl/sig_reg_pkg.sv | 28 ++
 rtl/sig_reg_fifo.sv | 57 +++++
 rtl/sig_reg_writer.sv | 111 +++++++++++
 tb/tb_sig_reg_writer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_reg_pkg.sv
// Shared types and constants for the signal-generator register write master.
// Field positions describe how a host byte splits into register address and data.
package sig_reg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam int ADDR_MSB = 7;
   localparam int ADDR_LSB = 5;
   localparam int DATA_MSB = 4;
   localparam int DATA_LSB = 0;

   localparam int DEF_FIFO_DEPTH    = 4;
   localparam int DEF_SETUP_CYCLES  = 2;
   localparam int DEF_STROBE_CYCLES = 100;
   localparam int DEF_HOLD_CYCLES   = 2;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sig_reg_fifo.sv
// Small synchronous FIFO buffering host write bytes ahead of the strobe sequencer.
// Full/empty come from a registered occupancy count, so a full FIFO refuses a push even when popping.
module sig_reg_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sig_reg_writer.sv
// Host-side write master: buffers host bytes and replays each as a stretched
// address/data/write_strobe transaction slow enough for the generator's scaled clock.
//
// state  | meaning
// IDLE   | waiting for a queued byte with ena high; pops it and latches address/data
// SETUP  | address/data stable, strobe low, SETUP_CYCLES long
// STROBE | write_strobe high, STROBE_CYCLES long
// HOLD   | strobe low, address/data still stable, HOLD_CYCLES long
module sig_reg_writer
   import sig_reg_pkg::*;
#(
   parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
   parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
   parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   output logic       write_strobe,
   output logic [2:0] address,
   output logic [4:0] data,
   output logic       busy
);
   localparam int MAX_CYCLES = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
   localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [7:0]    head;

   assign in_ready = !fifo_full;
   assign fifo_pop = (state == IDLE) && !fifo_empty && ena;
   assign busy     = (state != IDLE) || !fifo_empty;

   sig_reg_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid),
      .wdata (in_byte),
      .pop   (fifo_pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Each phase loads its length minus one and advances when the count reaches zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         write_strobe <= 1'b0;
         address      <= '0;
         data         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  address <= head[ADDR_MSB:ADDR_LSB];
                  data    <= head[DATA_MSB:DATA_LSB];
                  cnt     <= SETUP_LOAD;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  cnt          <= STROBE_LOAD;
                  write_strobe <= 1'b1;
                  state        <= STROBE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            STROBE: begin
               if (cnt == '0) begin
                  cnt          <= HOLD_LOAD;
                  write_strobe <= 1'b0;
                  state        <= HOLD;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               write_strobe <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sig_reg_writer.sv
// Self-checking bench for sig_reg_writer: a timestamp-based reference model checks every
// cycle, while table vectors and hand sequences add explicit timing and ordering checks.
module tb_sig_reg_writer;

   localparam int DEPTH = 4;
   localparam int S     = 2;
   localparam int T     = 100;
   localparam int H     = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       write_strobe;
   logic [2:0] address;
   logic [4:0] data;
   logic       busy;

   always #5 clk = ~clk;

   sig_reg_writer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_byte      (in_byte),
      .write_strobe (write_strobe),
      .address      (address),
      .data         (data),
      .busy         (busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: queued bytes plus the edge index of the most recent pop.
   logic [7:0] q[$];
   logic [7:0] last_byte;
   int         t;
   int         last_pop;
   int         free_at;
   bit         last_acc;

   // Observation of the DUT strobe, used by explicit timing checks.
   bit         prev_strobe;
   int         rises;
   int         rise_t;
   int         cur_len;
   int         last_len;
   int         idle_t;
   logic [2:0] rise_addr[$];
   logic [4:0] rise_data[$];

   typedef struct {
      logic [7:0] b;
      logic [2:0] a;
      logic [4:0] d;
   } vec_t;

   vec_t       vecs[6];
   logic [7:0] burst[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h expected %0h (edge %0d)", name, act, exp, t);
      end
   endtask

   task automatic model_reset();
      q.delete();
      last_byte   = 8'h00;
      last_pop    = t - 10000;
      free_at     = t;
      prev_strobe = 1'b0;
      cur_len     = 0;
   endtask

   // One clock cycle: drive inputs, predict, clock, compare against the prediction.
   task automatic step(input logic v, input logic [7:0] b, input logic e);
      bit do_push;
      bit do_pop;
      in_valid = v;
      in_byte  = b;
      ena      = e;
      chk("in_ready", in_ready, (q.size() < DEPTH));
      do_push  = v && (q.size() < DEPTH);
      do_pop   = (q.size() > 0) && e && (t >= free_at);
      last_acc = do_push;
      @(posedge clk);
      #1;
      if (do_pop) begin
         last_byte = q.pop_front();
         last_pop  = t;
         free_at   = t + S + T + H + 1;
      end
      if (do_push) q.push_back(b);
      chk("write_strobe", write_strobe, (t >= last_pop + S) && (t < last_pop + S + T));
      chk("busy", busy, (t < last_pop + S + T + H) || (q.size() > 0));
      chk("address", address, last_byte[7:5]);
      chk("data", data, last_byte[4:0]);
      if (write_strobe && !prev_strobe) begin
         rises++;
         rise_t  = t;
         cur_len = 0;
         rise_addr.push_back(address);
         rise_data.push_back(data);
      end
      if (write_strobe) cur_len++;
      if (!write_strobe && prev_strobe) last_len = cur_len;
      prev_strobe = write_strobe;
      t++;
   endtask

   task automatic run_until_idle(input int budget);
      int n = 0;
      do begin
         step(1'b0, 8'h00, 1'b1);
         n++;
      end while (busy && n < budget);
      idle_t = t - 1;
      chk("idle_within_budget", busy, 0);
   endtask

   task automatic wait_strobe(input int budget, input logic e);
      int n = 0;
      while (!write_strobe && n < budget) begin
         step(1'b0, 8'h00, e);
         n++;
      end
      chk("strobe_within_budget", write_strobe, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int acc_t;
      int r0;
      int te;

      vecs[0] = '{8'hA5, 3'd5, 5'd5};
      vecs[1] = '{8'h21, 3'd1, 5'd1};
      vecs[2] = '{8'hFF, 3'd7, 5'd31};
      vecs[3] = '{8'h00, 3'd0, 5'd0};
      vecs[4] = '{8'hE0, 3'd7, 5'd0};
      vecs[5] = '{8'h1F, 3'd0, 5'd31};
      burst   = '{8'h3C, 8'hC3, 8'h5A, 8'h81, 8'h7E};

      rst_n    = 1'b0;
      ena      = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      t        = 0;
      rises    = 0;
      last_len = 0;
      model_reset();
      #1;
      chk("rst_strobe", write_strobe, 0);
      chk("rst_address", address, 0);
      chk("rst_data", data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Single writes from a table: latency, strobe width and busy duration.
      foreach (vecs[i]) begin
         r0 = rises;
         step(1'b1, vecs[i].b, 1'b1);
         acc_t = t - 1;
         chk("tbl_accept", last_acc, 1);
         step(1'b0, 8'h00, 1'b1);
         chk("tbl_address", address, vecs[i].a);
         chk("tbl_data", data, vecs[i].d);
         run_until_idle(400);
         chk("tbl_rises", rises - r0, 1);
         chk("tbl_rise_ofs", rise_t - acc_t, S + 1);
         chk("tbl_strobe_len", last_len, T);
         chk("tbl_busy_fall", idle_t - acc_t, S + T + H + 1);
      end

      // Fill with ena low, then a pop edge with in_valid high: push refused, then taken.
      rise_addr.delete();
      rise_data.delete();
      r0 = rises;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, burst[i], 1'b0);
         chk("fill_accept", last_acc, 1);
      end
      chk("full_ready_low", in_ready, 0);
      step(1'b1, burst[4], 1'b1);
      chk("full_pop_refused", last_acc, 0);
      chk("ready_after_pop", in_ready, 1);
      step(1'b1, burst[4], 1'b1);
      chk("fifth_accept", last_acc, 1);
      run_until_idle(1000);
      chk("burst_rises", rises - r0, 5);
      for (int i = 0; i < 5; i++) begin
         if (i < rise_addr.size()) begin
            chk("burst_addr", rise_addr[i], burst[i][7:5]);
            chk("burst_data", rise_data[i], burst[i][4:0]);
         end else begin
            chk("burst_missing", i, rise_addr.size());
         end
      end

      // ena gating: queued byte waits, then strobes S+1 edges after ena rises.
      r0 = rises;
      step(1'b1, 8'h21, 1'b0);
      chk("gate_accept", last_acc, 1);
      repeat (20) step(1'b0, 8'h00, 1'b0);
      chk("gate_busy", busy, 1);
      chk("gate_no_strobe", rises - r0, 0);
      te = t;
      repeat (S + 1) step(1'b0, 8'h00, 1'b1);
      chk("gate_rise", rises - r0, 1);
      chk("gate_rise_ofs", rise_t - te, S);
      run_until_idle(400);

      // ena drop mid-strobe with two entries queued.
      r0 = rises;
      step(1'b1, 8'h9A, 1'b1);
      step(1'b1, 8'h45, 1'b1);
      step(1'b1, 8'hF0, 1'b1);
      wait_strobe(10, 1'b1);
      repeat (10) step(1'b0, 8'h00, 1'b1);
      repeat (300) step(1'b0, 8'h00, 1'b0);
      chk("drop_len", last_len, T);
      chk("drop_rises", rises - r0, 1);
      chk("drop_busy", busy, 1);
      run_until_idle(600);
      chk("drop_total_rises", rises - r0, 3);

      // Reset at strobe cycle 40.
      r0 = rises;
      step(1'b1, 8'h5A, 1'b1);
      wait_strobe(10, 1'b1);
      repeat (39) step(1'b0, 8'h00, 1'b1);
      chk("pre_rst_strobe", write_strobe, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_strobe", write_strobe, 0);
      chk("mid_rst_address", address, 0);
      chk("mid_rst_data", data, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (200) step(1'b0, 8'h00, 1'b1);
      chk("post_rst_rises", rises - r0, 1);

      // Randomized traffic against the reference model.
      repeat (3000) begin
         step(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 15) != 0));
      end
      run_until_idle(1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
